// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for a five-stage pipeline.
// It detects load-use hazards and sequences a 32-cycle multi-cycle divide.
// It steers the PC and IF/ID enables, and it flushes IF/ID on a taken branch
// or when instruction memory is not ready.
// It also tracks fetch timeouts and accumulates the number of stall cycles.
// The control outputs are combinational: ID needs them in the same cycle
// that the hazard appears.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rs_i,
  input  logic        id_uses_rt_i,
  input  logic        id_is_div_i,
  input  logic        id_branch_taken_i,
  input  logic        ex_wreg_i,
  input  logic        ex_m2reg_i,
  input  logic [4:0]  ex_rn_i,
  input  logic        imem_ready_i,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
  output logic        id_bubble_o,
  output logic        div_start_o,
  output logic        div_done_o,
  output logic        fetch_err_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_DIV = 1'b1;

  localparam logic [4:0]  DIV_LOAD   = 5'd31;
  localparam logic [7:0]  FWAIT_MAX  = 8'hFF;
  localparam logic [15:0] STALL_MAX  = 16'hFFFF;

  logic [0:0]  state_q, state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [7:0]  fwait_q, fwait_d;
  logic        fetch_err_q, fetch_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use;

  // Load-use hazard: the EX load targets a nonzero register that ID reads.
  always_comb begin
    load_use = ex_wreg_i & ex_m2reg_i & (ex_rn_i != 5'd0) &
               ((id_uses_rs_i & (ex_rn_i == id_rs_i)) |
                (id_uses_rt_i & (ex_rn_i == id_rt_i)));
  end

  // Control decode and next state. While stalled, a branch is held rather than flushed.
  always_comb begin
    pc_en_o      = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    id_bubble_o  = 1'b0;
    div_start_o  = 1'b0;
    div_done_o   = 1'b0;
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          id_bubble_o = 1'b1;
        end else if (id_is_div_i) begin
          id_bubble_o = 1'b1;
          div_start_o = 1'b1;
          state_d     = ST_DIV;
          div_cnt_d   = DIV_LOAD;
        end else begin
          ifid_en_o    = 1'b1;
          pc_en_o      = imem_ready_i | id_branch_taken_i;
          ifid_flush_o = id_branch_taken_i | ~imem_ready_i;
        end
      end
      ST_DIV: begin
        // Hazard and branch inputs are ignored until the divide completes.
        if (div_cnt_q == 5'd0) begin
          div_done_o   = 1'b1;
          ifid_en_o    = 1'b1;
          pc_en_o      = imem_ready_i;
          ifid_flush_o = ~imem_ready_i;
          state_d      = ST_RUN;
        end else begin
          id_bubble_o = 1'b1;
          div_cnt_d   = div_cnt_q - 5'd1;
        end
      end
      default: begin
        id_bubble_o = 1'b1;
        state_d     = ST_RUN;
        div_cnt_d   = 5'd0;
      end
    endcase
  end

  // Fetch-wait counter saturates; the timeout flag is sticky until reset.
  always_comb begin
    if (imem_ready_i) begin
      fwait_d = 8'd0;
    end else if (fwait_q != FWAIT_MAX) begin
      fwait_d = fwait_q + 8'd1;
    end else begin
      fwait_d = fwait_q;
    end
    if ((fwait_q == FWAIT_MAX) && !imem_ready_i) begin
      fetch_err_d = 1'b1;
    end else begin
      fetch_err_d = fetch_err_q;
    end
  end

  // Count cycles in which the PC is held, saturating at full scale.
  always_comb begin
    if (!pc_en_o && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State register with asynchronous clear. A reset during a divide abandons it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_RUN;
      div_cnt_q   <= 5'd0;
      fwait_q     <= 8'd0;
      fetch_err_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      fwait_q     <= fwait_d;
      fetch_err_q <= fetch_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_err_o = fetch_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expected values.
module tb_pipeline_ctrl;

  logic        clk;
  logic        clrn;
  logic [4:0]  id_rs_i, id_rt_i, ex_rn_i;
  logic        id_uses_rs_i, id_uses_rt_i, id_is_div_i, id_branch_taken_i;
  logic        ex_wreg_i, ex_m2reg_i, imem_ready_i;
  logic        pc_en_o, ifid_en_o, ifid_flush_o, id_bubble_o;
  logic        div_start_o, div_done_o, fetch_err_o;
  logic [15:0] stall_cnt_o;

  int n_checks;
  int n_errors;

  pipeline_ctrl dut (
    .clk               (clk),
    .clrn              (clrn),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_uses_rs_i      (id_uses_rs_i),
    .id_uses_rt_i      (id_uses_rt_i),
    .id_is_div_i       (id_is_div_i),
    .id_branch_taken_i (id_branch_taken_i),
    .ex_wreg_i         (ex_wreg_i),
    .ex_m2reg_i        (ex_m2reg_i),
    .ex_rn_i           (ex_rn_i),
    .imem_ready_i      (imem_ready_i),
    .pc_en_o           (pc_en_o),
    .ifid_en_o         (ifid_en_o),
    .ifid_flush_o      (ifid_flush_o),
    .id_bubble_o       (id_bubble_o),
    .div_start_o       (div_start_o),
    .div_done_o        (div_done_o),
    .fetch_err_o       (fetch_err_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 2 ns into the cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rn_i = 5'd0;
    id_uses_rs_i = 1'b0; id_uses_rt_i = 1'b0; id_is_div_i = 1'b0;
    id_branch_taken_i = 1'b0; ex_wreg_i = 1'b0; ex_m2reg_i = 1'b0;
    imem_ready_i = 1'b1;
  endtask

  // Pulse the reset low in the middle of a cycle, away from any clock edge.
  task automatic pulse_reset();
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rn);
    ex_wreg_i = 1'b1; ex_m2reg_i = 1'b1; ex_rn_i = rn;
    id_rs_i = 5'd5; id_uses_rs_i = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    clrn = 1'b0;
    #2;
    check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    check("rst_pc_en", 32'(pc_en_o), 32'd1);
    check("rst_div_done", 32'(div_done_o), 32'd0);
    clrn = 1'b1;
    step();
    step();
    check("idle_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Load-use hazard through rs.
    set_load_use(5'd5);
    #1;
    check("lu_pc_en", 32'(pc_en_o), 32'd0);
    check("lu_ifid_en", 32'(ifid_en_o), 32'd0);
    check("lu_bubble", 32'(id_bubble_o), 32'd1);
    check("lu_flush", 32'(ifid_flush_o), 32'd0);
    check("lu_div_start", 32'(div_start_o), 32'd0);
    step();
    idle_inputs();
    #1;
    check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // A load to r0 is never a hazard.
    set_load_use(5'd0);
    #1;
    check("r0_pc_en", 32'(pc_en_o), 32'd1);
    check("r0_ifid_en", 32'(ifid_en_o), 32'd1);
    check("r0_bubble", 32'(id_bubble_o), 32'd0);
    // A hazard through rt is detected only when ID actually reads rt.
    idle_inputs();
    ex_wreg_i = 1'b1; ex_m2reg_i = 1'b1; ex_rn_i = 5'd9; id_rt_i = 5'd9;
    #1;
    check("rt_unused_pc_en", 32'(pc_en_o), 32'd1);
    id_uses_rt_i = 1'b1;
    #1;
    check("rt_used_pc_en", 32'(pc_en_o), 32'd0);
    // A hazard from a non-load instruction causes no stall.
    ex_m2reg_i = 1'b0;
    #1;
    check("nonload_pc_en", 32'(pc_en_o), 32'd1);
    idle_inputs();

    // A taken branch while instruction memory is not ready.
    id_branch_taken_i = 1'b1; imem_ready_i = 1'b0;
    #1;
    check("br_pc_en", 32'(pc_en_o), 32'd1);
    check("br_flush", 32'(ifid_flush_o), 32'd1);
    set_load_use(5'd5);
    #1;
    check("br_lu_flush", 32'(ifid_flush_o), 32'd0);
    check("br_lu_pc_en", 32'(pc_en_o), 32'd0);
    idle_inputs();
    imem_ready_i = 1'b0;
    #1;
    check("nrdy_pc_en", 32'(pc_en_o), 32'd0);
    check("nrdy_flush", 32'(ifid_flush_o), 32'd1);
    check("nrdy_ifid_en", 32'(ifid_en_o), 32'd1);
    idle_inputs();

    // Divide: 32 stall cycles, then issue on cycle 32.
    pulse_reset();
    check("div_pre_stall", 32'(stall_cnt_o), 32'd0);
    id_is_div_i = 1'b1;
    #1;
    check("div_start_c0", 32'(div_start_o), 32'd1);
    check("div_pc_en_c0", 32'(pc_en_o), 32'd0);
    check("div_bubble_c0", 32'(id_bubble_o), 32'd1);
    step();
    // Hazard and branch inputs must be ignored while dividing.
    idle_inputs();
    set_load_use(5'd5);
    id_branch_taken_i = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      #1;
      check($sformatf("div_pc_en_c%0d", k), 32'(pc_en_o), 32'd0);
      check($sformatf("div_done_c%0d", k), 32'(div_done_o), 32'd0);
      check($sformatf("div_start_c%0d", k), 32'(div_start_o), 32'd0);
      step();
    end
    #1;
    check("div_done_c32", 32'(div_done_o), 32'd1);
    check("div_pc_en_c32", 32'(pc_en_o), 32'd1);
    check("div_ifid_en_c32", 32'(ifid_en_o), 32'd1);
    check("div_bubble_c32", 32'(id_bubble_o), 32'd0);
    check("div_flush_c32", 32'(ifid_flush_o), 32'd0);
    check("div_stall_c32", 32'(stall_cnt_o), 32'd32);
    idle_inputs();
    step();
    check("div_after_done", 32'(div_done_o), 32'd0);
    check("div_after_pc_en", 32'(pc_en_o), 32'd1);
    check("div_after_stall", 32'(stall_cnt_o), 32'd32);

    // Reset while the divide counter is 10 (cycle 22) abandons the divide.
    id_is_div_i = 1'b1;
    step();
    id_is_div_i = 1'b0;
    for (int k = 1; k < 22; k++) step();
    clrn = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall_cnt_o), 32'd0);
    check("mid_rst_pc_en", 32'(pc_en_o), 32'd1);
    check("mid_rst_done", 32'(div_done_o), 32'd0);
    clrn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("mid_rst_nodone_%0d", k), 32'(div_done_o), 32'd0);
    end
    check("mid_rst_stall_end", 32'(stall_cnt_o), 32'd0);

    // Fetch timeout: the flag is set on the 256th edge with memory not ready.
    pulse_reset();
    imem_ready_i = 1'b0;
    for (int k = 0; k < 255; k++) step();
    check("ferr_255", 32'(fetch_err_o), 32'd0);
    step();
    check("ferr_256", 32'(fetch_err_o), 32'd1);
    imem_ready_i = 1'b1;
    step();
    step();
    check("ferr_sticky", 32'(fetch_err_o), 32'd1);
    check("ferr_stall_cnt", 32'(stall_cnt_o), 32'd256);
    clrn = 1'b0;
    #1;
    check("ferr_clear", 32'(fetch_err_o), 32'd0);
    clrn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
